// File: rtl/response_bus_arbiter_pkg.sv
// Shared types and widths for the response-bus arbiter and its round-robin picker.
// Both arbiter flavours (request and response bus) import this package.
package response_bus_arbiter_pkg;

   localparam int TAG_WIDTH = 8;

   typedef enum logic [1:0] {
      ARB    = 2'd0,
      GRANT  = 2'd1,
      TENURE = 2'd2
   } resp_arb_state_e;

endpackage

// File: rtl/response_bus_arbiter_rr_select.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Returns one-hot winner, its index and whether anything was requesting.
module rr_select #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt_oh,
   output logic [IW-1:0] gnt_idx,
   output logic          any
);

   logic [N-1:0][IW-1:0] cand;

   // cand[k] is the k-th source in search order starting from ptr
   for (genvar k = 0; k < N; k++) begin : g_cand
      assign cand[k] = IW'((int'(ptr) + k) % N);
   end

   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!any && req[cand[k]]) begin
            any             = 1'b1;
            gnt_idx         = cand[k];
            gnt_oh[cand[k]] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/response_bus_arbiter.sv
// Response-bus arbiter: round-robin tenure grants, OR-merge of source outputs,
// and sticky protocol-violation flags for multiple or non-owner drivers.
module response_bus_arbiter
   import response_bus_arbiter_pkg::*;
#(
   parameter int NUM_SOURCES = 4,
   parameter int DATA_W      = 128,
   parameter int TAG_W       = TAG_WIDTH,
   parameter int OW          = $clog2(NUM_SOURCES)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_SOURCES-1:0]        src_breq,
   input  logic [NUM_SOURCES-1:0]        src_bhold,
   output logic [NUM_SOURCES-1:0]        src_bgnt,
   input  logic [NUM_SOURCES*DATA_W-1:0] src_data,
   input  logic [NUM_SOURCES*TAG_W-1:0]  src_tag,
   input  logic [NUM_SOURCES-1:0]        src_oe,
   output logic [DATA_W-1:0]             bus_data,
   output logic [TAG_W-1:0]              bus_tag,
   output logic                          bus_valid,
   output logic [OW-1:0]                 bus_owner,
   output logic                          err_collision,
   output logic                          err_unowned
);

   resp_arb_state_e        state_q, state_d;
   logic [OW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [OW-1:0]          owner_q, owner_d;
   logic [NUM_SOURCES-1:0] bgnt_q, bgnt_d;
   logic                   err_col_q, err_col_d;
   logic                   err_un_q, err_un_d;

   logic [NUM_SOURCES-1:0] win_oh;
   logic [OW-1:0]          win_idx;
   logic                   win_any;

   logic [NUM_SOURCES-1:0][DATA_W-1:0] data_arr;
   logic [NUM_SOURCES-1:0][TAG_W-1:0]  tag_arr;
   logic [NUM_SOURCES-1:0]             owner_oh;
   logic [NUM_SOURCES-1:0]             legal_oe;
   logic                               multi_oe;
   logic                               stray_oe;

   rr_select #(
      .N  (NUM_SOURCES),
      .IW (OW)
   ) u_rr_select (
      .req     (src_breq),
      .ptr     (rr_ptr_q),
      .gnt_oh  (win_oh),
      .gnt_idx (win_idx),
      .any     (win_any)
   );

   for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_unflat
      assign data_arr[i] = src_data[i*DATA_W +: DATA_W];
      assign tag_arr[i]  = src_tag[i*TAG_W +: TAG_W];
   end

   always_comb begin
      bus_data = '0;
      bus_tag  = '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         if (src_oe[i]) begin
            bus_data = bus_data | data_arr[i];
            bus_tag  = bus_tag | tag_arr[i];
         end
      end
   end

   assign bus_valid = |src_oe;

   // x & (x-1) clears the lowest set bit; anything left means two or more drivers
   assign multi_oe = |(src_oe & (src_oe - NUM_SOURCES'(1)));
   assign owner_oh = NUM_SOURCES'(1) << owner_q;
   assign legal_oe = (state_q == TENURE) ? owner_oh : '0;
   assign stray_oe = |(src_oe & ~legal_oe);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ARB;
         rr_ptr_q  <= '0;
         owner_q   <= '0;
         bgnt_q    <= '0;
         err_col_q <= 1'b0;
         err_un_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         owner_q   <= owner_d;
         bgnt_q    <= bgnt_d;
         err_col_q <= err_col_d;
         err_un_q  <= err_un_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB:     if (win_any) state_d = GRANT;
         GRANT:   state_d = TENURE;
         TENURE:  if (!src_bhold[owner_q]) state_d = ARB;
         default: state_d = ARB;
      endcase
   end

   // Arbitration only happens in ARB, so the owner's still-high breq during GRANT is ignored
   always_comb begin
      bgnt_d    = '0;
      owner_d   = owner_q;
      rr_ptr_d  = rr_ptr_q;
      err_col_d = err_col_q | multi_oe;
      err_un_d  = err_un_q | stray_oe;
      if (state_q == ARB && win_any) begin
         bgnt_d   = win_oh;
         owner_d  = win_idx;
         rr_ptr_d = (win_idx == OW'(NUM_SOURCES - 1)) ? '0 : win_idx + OW'(1);
      end
   end

   assign src_bgnt      = bgnt_q;
   assign bus_owner     = owner_q;
   assign err_collision = err_col_q;
   assign err_unowned   = err_un_q;

endmodule
